// File: rtl/button_pulse_bank_pkg.sv
// button_pulse_bank_pkg: edge-mode encodings, default parameters and helpers shared by the button bank.
package button_pulse_bank_pkg;
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;
  localparam int DEF_CHANNELS = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_EDGE_MODE = EDGE_RISE;
  localparam int DEF_REPEAT_DELAY = 500;
  localparam int DEF_REPEAT_PERIOD = 100;
  // Unknown modes fall back to rising-edge behaviour.
  function automatic logic edge_hit(input int mode, input logic new_level);
    return mode == EDGE_BOTH ? 1'b1 : mode == EDGE_FALL ? !new_level : new_level;
  endfunction
  function automatic int imax(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/button_pulse_chan.sv
// button_pulse_chan: one channel -- 2-flop synchronizer, debounce filter, edge pulse.
// Auto-repeat while held is compiled in only with BUTTON_REPEAT_EN.
module button_pulse_chan
  import button_pulse_bank_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int EDGE_MODE       = DEF_EDGE_MODE,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  output logic button_level,
  output logic button_one_shot
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_pulse;
  logic          w_diff;
  logic          w_accept;
  logic          w_rep_hit;
  assign w_diff          = r_sync[1] != r_level;
  assign w_accept        = w_diff && r_cnt == CW'(DEBOUNCE_CYCLES - 1);
  assign button_level    = r_level;
  assign button_one_shot = r_pulse;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], button};
      r_cnt   <= w_diff && !w_accept ? r_cnt + 1'b1 : '0;
      r_level <= w_accept ? !r_level : r_level;
      r_pulse <= (w_accept && edge_hit(EDGE_MODE, !r_level)) || w_rep_hit;
    end
  end
`ifdef BUTTON_REPEAT_EN
  localparam int RW = $clog2(imax(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  logic [RW-1:0] r_rep;
  logic          r_rep_ph;
  // Phase 0 waits out the initial delay, phase 1 repeats every period.
  assign w_rep_hit = r_level && !w_accept
                     && r_rep == RW'((r_rep_ph ? REPEAT_PERIOD : REPEAT_DELAY) - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rep    <= '0;
      r_rep_ph <= 1'b0;
    end else if (!r_level || w_accept) begin
      r_rep    <= '0;
      r_rep_ph <= 1'b0;
    end else if (w_rep_hit) begin
      r_rep    <= '0;
      r_rep_ph <= 1'b1;
    end else begin
      r_rep    <= r_rep + 1'b1;
    end
  end
`else
  assign w_rep_hit = REPEAT_DELAY < 0 && REPEAT_PERIOD < 0;
`endif
endmodule

// File: rtl/button_pulse_bank.sv
// button_pulse_bank: CHANNELS independent debounced buttons with one-shot pulses and a combined OR.
// Optional auto-repeat via BUTTON_REPEAT_EN.
module button_pulse_bank
  import button_pulse_bank_pkg::*;
#(
  parameter int CHANNELS        = DEF_CHANNELS,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int EDGE_MODE       = DEF_EDGE_MODE,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] button,
  output logic [CHANNELS-1:0] button_level,
  output logic [CHANNELS-1:0] button_one_shot,
  output logic                any_one_shot
);
  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    button_pulse_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .EDGE_MODE      (EDGE_MODE),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_chan (
      .clk            (clk),
      .rst_n          (rst_n),
      .button         (button[i]),
      .button_level   (button_level[i]),
      .button_one_shot(button_one_shot[i])
    );
  end
  assign any_one_shot = |button_one_shot;
endmodule
